// File: rtl/fifo_sync_ctl.sv
// fifo_sync_ctl: single-clock FIFO controller with a binary occupancy
// counter, programmable almost-full/almost-empty thresholds, a fill-level
// output and sticky overflow/underflow error flags.
//
// Optional feature macro: FIFO_SYNC_FWFT_EN
//   undefined : rdata is registered and updates on the edge after an
//               accepted read (1-cycle read latency).
//   defined   : first-word-fall-through; rdata shows the head entry
//               whenever rempty=0 and rinc acts as a pop acknowledge.
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   wdata, winc    write data / write request
//   wfull          FIFO full (level == 2^ASIZE)
//   walmost_full   level >= AF_THRESH
//   rinc, rdata    read request / read data
//   rempty         FIFO empty (level == 0)
//   ralmost_empty  level <= AE_THRESH
//   level          current occupancy, 0..2^ASIZE
//   overflow       sticky: write attempted while full
//   underflow      sticky: read attempted while empty
//   clr_err        clears overflow/underflow (a new error in the same cycle wins)

module fifo_sync_ctl #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AF_THRESH = (1 << ASIZE) - 2,
    parameter int AE_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   level,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_LVL = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF_LVL    = (ASIZE+1)'(AF_THRESH);
    localparam logic [ASIZE:0] AE_LVL    = (ASIZE+1)'(AE_THRESH);

    logic [DSIZE-1:0] mem_q [DEPTH];

    logic [ASIZE-1:0] waddr_q, waddr_d;
    logic [ASIZE-1:0] raddr_q, raddr_d;
    logic [ASIZE:0]   level_q, level_d;
    logic             wfull_q, wfull_d;
    logic             rempty_q, rempty_d;
    logic             walmost_full_q, walmost_full_d;
    logic             ralmost_empty_q, ralmost_empty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_en;
    logic             rd_en;

    // Accept decisions use this cycle's registered flags, so a full FIFO
    // can still pop and an empty FIFO can still push in the same cycle.
    always_comb begin
        wr_en = winc && !wfull_q;
        rd_en = rinc && !rempty_q;
    end

    // Next-state for pointers, occupancy, status flags and error flags.
    // Status flags come from level_d so that, once registered, they are
    // always coherent with the level output of the same cycle.
    always_comb begin
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_en) begin
            waddr_d = waddr_q + 1'b1;
        end
        if (rd_en) begin
            raddr_d = raddr_q + 1'b1;
        end
        if (wr_en && !rd_en) begin
            level_d = level_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            level_d = level_q - 1'b1;
        end

        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (winc && wfull_q) begin
            overflow_d = 1'b1;
        end
        if (rinc && rempty_q) begin
            underflow_d = 1'b1;
        end

        wfull_d         = (level_d == DEPTH_LVL);
        rempty_d        = (level_d == '0);
        walmost_full_d  = (level_d >= AF_LVL);
        ralmost_empty_d = (level_d <= AE_LVL);
    end

    // Control state register; reset discards all queued entries by
    // returning both pointers and the level to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_q         <= '0;
            raddr_q         <= '0;
            level_q         <= '0;
            wfull_q         <= 1'b0;
            rempty_q        <= 1'b1;
            walmost_full_q  <= 1'b0;
            ralmost_empty_q <= 1'b1;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            waddr_q         <= waddr_d;
            raddr_q         <= raddr_d;
            level_q         <= level_d;
            wfull_q         <= wfull_d;
            rempty_q        <= rempty_d;
            walmost_full_q  <= walmost_full_d;
            ralmost_empty_q <= ralmost_empty_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
        end
    end

    // Storage array is not reset; writes are blocked during reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[waddr_q] <= wdata;
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    // Head entry falls through combinationally; don't-care while empty.
    always_comb begin
        rdata = mem_q[raddr_q];
    end
`else
    logic [DSIZE-1:0] rdata_q, rdata_d;

    // Registered read port: captures the head on an accepted read,
    // otherwise holds the last value.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = mem_q[raddr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        rdata = rdata_q;
    end
`endif

    always_comb begin
        wfull         = wfull_q;
        rempty        = rempty_q;
        walmost_full  = walmost_full_q;
        ralmost_empty = ralmost_empty_q;
        level         = level_q;
        overflow      = overflow_q;
        underflow     = underflow_q;
    end

endmodule

// File: tb/tb_fifo_sync_ctl.sv
// tb_fifo_sync_ctl: self-checking bench for fifo_sync_ctl (ASIZE=4,
// AF_THRESH=14, AE_THRESH=2). A queue-based reference model is updated
// by the stimulus task on each rising edge; a compare process checks
// every output against it on each falling edge, and directed literal
// checks pin the model at the interesting points.

module tb_fifo_sync_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdata = '0;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic       clr_err = 1'b0;
    logic       wfull;
    logic       walmost_full;
    logic [7:0] rdata;
    logic       rempty;
    logic       ralmost_empty;
    logic [4:0] level;
    logic       overflow;
    logic       underflow;

    int  checkCount = 0;
    int  failCount  = 0;
    bit  checkEn    = 1'b0;

    // Reference model: a plain queue of stored words plus the read register
    // and the two sticky error bits.
    logic [7:0] modelQ[$];
    logic [7:0] modelRdata = '0;
    bit         modelOvf   = 1'b0;
    bit         modelUnf   = 1'b0;

    fifo_sync_ctl #(
        .DSIZE(8),
        .ASIZE(4),
        .AF_THRESH(14),
        .AE_THRESH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wdata(wdata),
        .winc(winc),
        .wfull(wfull),
        .walmost_full(walmost_full),
        .rinc(rinc),
        .rdata(rdata),
        .rempty(rempty),
        .ralmost_empty(ralmost_empty),
        .level(level),
        .overflow(overflow),
        .underflow(underflow),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let the DUT take the edge, and advance the
    // model using the occupancy it held before the edge.
    task automatic applyStimulus(input bit r, input bit w, input logic [7:0] d,
                                 input bit rd, input bit c);
        bit wasFull;
        bit wasEmpty;
        rst     = r;
        winc    = w;
        wdata   = d;
        rinc    = rd;
        clr_err = c;
        @(posedge clk);
        if (r) begin
            modelQ.delete();
            modelRdata = '0;
            modelOvf   = 1'b0;
            modelUnf   = 1'b0;
        end else begin
            wasFull  = (modelQ.size() == 16);
            wasEmpty = (modelQ.size() == 0);
            if (rd && !wasEmpty) modelRdata = modelQ.pop_front();
            if (w && !wasFull) modelQ.push_back(d);
            if (c) begin
                modelOvf = 1'b0;
                modelUnf = 1'b0;
            end
            if (w && wasFull) modelOvf = 1'b1;
            if (rd && wasEmpty) modelUnf = 1'b1;
        end
        #1;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("level", level, modelQ.size());
            checkOutput("wfull", wfull, modelQ.size() == 16);
            checkOutput("rempty", rempty, modelQ.size() == 0);
            checkOutput("walmost_full", walmost_full, modelQ.size() >= 14);
            checkOutput("ralmost_empty", ralmost_empty, modelQ.size() <= 2);
            checkOutput("overflow", overflow, modelOvf);
            checkOutput("underflow", underflow, modelUnf);
`ifdef FIFO_SYNC_FWFT_EN
            if (modelQ.size() > 0) checkOutput("rdata_head", rdata, modelQ[0]);
`else
            checkOutput("rdata", rdata, modelRdata);
`endif
        end
    end

    initial begin
        logic [7:0] wd;

        applyStimulus(1, 0, 8'h00, 0, 0);
        applyStimulus(1, 0, 8'h00, 0, 0);
        checkEn = 1'b1;

        // Reset then idle
        applyStimulus(0, 0, 8'h00, 0, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_rempty", rempty, 1);
        checkOutput("rst_ralmost_empty", ralmost_empty, 1);
        checkOutput("rst_wfull", wfull, 0);
        checkOutput("rst_walmost_full", walmost_full, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_underflow", underflow, 0);
`ifndef FIFO_SYNC_FWFT_EN
        checkOutput("rst_rdata", rdata, 0);
`endif

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 1, 8'(i), 0, 0);
            if (i == 1)  checkOutput("rempty_after_w1", rempty, 0);
            if (i == 13) checkOutput("walmost_full_at13", walmost_full, 0);
            if (i == 14) checkOutput("walmost_full_at14", walmost_full, 1);
            if (i == 15) checkOutput("wfull_at15", wfull, 0);
        end
        checkOutput("full_level", level, 16);
        checkOutput("full_wfull", wfull, 1);

        // 17th write is rejected
        applyStimulus(0, 1, 8'hEE, 0, 0);
        checkOutput("ovf_set", overflow, 1);
        checkOutput("ovf_level", level, 16);
        applyStimulus(0, 0, 8'h00, 0, 1);
        checkOutput("ovf_clr", overflow, 0);

        // Drain in order
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 0, 8'h00, 1, 0);
`ifndef FIFO_SYNC_FWFT_EN
            checkOutput("drain_rdata", rdata, 8'(i));
`endif
            if (i == 13) checkOutput("ralmost_empty_lvl3", ralmost_empty, 0);
            if (i == 14) checkOutput("ralmost_empty_lvl2", ralmost_empty, 1);
            if (i == 15) checkOutput("rempty_lvl1", rempty, 0);
        end
        checkOutput("drain_rempty", rempty, 1);
        checkOutput("drain_level", level, 0);

        // Extra read is rejected
        applyStimulus(0, 0, 8'h00, 1, 0);
        checkOutput("unf_set", underflow, 1);
`ifndef FIFO_SYNC_FWFT_EN
        checkOutput("unf_rdata_hold", rdata, 8'h10);
`endif
        applyStimulus(0, 0, 8'h00, 0, 1);
        checkOutput("unf_clr", underflow, 0);

        // Pointer wrap: preload 7, then 40 writes/40 reads keeping level 7..8
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 8'h20 + 8'(i), 0, 0);
        wd = 8'h40;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, wd, 1, 0);
            wd++;
            applyStimulus(0, 1, wd, 0, 0);
            wd++;
            applyStimulus(0, 0, 8'h00, 1, 0);
        end
        checkOutput("wrap_level", level, 7);

        // Simultaneous at full: read accepted, write rejected
        for (int i = 0; i < 9; i++) applyStimulus(0, 1, 8'h80 + 8'(i), 0, 0);
        checkOutput("sim_full_pre", wfull, 1);
        applyStimulus(0, 1, 8'hCC, 1, 0);
        checkOutput("sim_full_level", level, 15);
        checkOutput("sim_full_ovf", overflow, 1);

        // Simultaneous at empty: write accepted, read rejected
        for (int i = 0; i < 15; i++) applyStimulus(0, 0, 8'h00, 1, 0);
        checkOutput("sim_empty_pre", level, 0);
        applyStimulus(0, 1, 8'h5A, 1, 0);
        checkOutput("sim_empty_level", level, 1);
        checkOutput("sim_empty_unf", underflow, 1);

        // Simultaneous at level 8
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 8'h60 + 8'(i), 0, 0);
        applyStimulus(0, 1, 8'h6F, 1, 0);
        checkOutput("sim_mid_level", level, 8);
        applyStimulus(0, 0, 8'h00, 0, 1);
        checkOutput("clr_ovf", overflow, 0);
        checkOutput("clr_unf", underflow, 0);

        // Reset with level 9 and active inputs
        applyStimulus(0, 1, 8'h70, 0, 0);
        checkOutput("pre_rst_level", level, 9);
        applyStimulus(1, 1, 8'hFF, 1, 0);
        checkOutput("midrst_level", level, 0);
        checkOutput("midrst_rempty", rempty, 1);
        applyStimulus(0, 1, 8'hB1, 0, 0);
        applyStimulus(0, 1, 8'hB2, 0, 0);
`ifdef FIFO_SYNC_FWFT_EN
        checkOutput("post_rst_head1", rdata, 8'hB1);
        applyStimulus(0, 0, 8'h00, 1, 0);
        checkOutput("post_rst_head2", rdata, 8'hB2);
        applyStimulus(0, 0, 8'h00, 1, 0);
`else
        applyStimulus(0, 0, 8'h00, 1, 0);
        checkOutput("post_rst_rd1", rdata, 8'hB1);
        applyStimulus(0, 0, 8'h00, 1, 0);
        checkOutput("post_rst_rd2", rdata, 8'hB2);
`endif
        checkOutput("post_rst_empty", rempty, 1);

`ifdef FIFO_SYNC_FWFT_EN
        // Fall-through: data visible without rinc
        applyStimulus(0, 1, 8'hA5, 0, 0);
        checkOutput("fwft_rempty", rempty, 0);
        checkOutput("fwft_rdata", rdata, 8'hA5);
        applyStimulus(0, 0, 8'h00, 1, 0);
        checkOutput("fwft_pop_rempty", rempty, 1);
`endif

        applyStimulus(0, 0, 8'h00, 0, 0);
        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
